audiobar_ctrl: RTL and testbench

Host-facing controller that sequences the audio bar overlay stage. It latches PCM samples from the audio path and holds them steady for the overlay. It drives the overlay's `mute` and `bar_color` inputs, and runs a per-frame fade-in/fade-out state machine so the bar never appears or vanishes mid-frame. It also keeps a read-to-clear peak meter for firmware.

---
 rtl/audiobar_ctrl_pkg.sv | 30 +++
 rtl/audiobar_ctrl_scale.sv | 70 +++++++
 rtl/audiobar_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_audiobar_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audiobar_ctrl_pkg.sv
// Shared definitions for the audio bar controller: register map, fade states,
// CTRL field positions and the PCM peak-magnitude helper.
package audiobar_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_COLOR  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_PEAK   = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FREEZE_BIT = 1;
  localparam int CTRL_STEP_LSB   = 8;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_FADEIN  = 2'd1,
    ST_ON      = 2'd2,
    ST_FADEOUT = 2'd3
  } fade_state_t;

  // |x| clamped to 32767, top 8 of the 15 magnitude bits; -32768 lands on 8'hFF.
  function automatic logic [7:0] peak_mag(input logic [15:0] x);
    logic [15:0] a;
    logic [14:0] c;
    a = x[15] ? (~x + 16'd1) : x;
    c = a[15] ? 15'h7FFF : a[14:0];
    return 8'(c >> 7);
  endfunction

endpackage

// File: rtl/audiobar_ctrl_scale.sv
// Sequential R/G/B colour scaler on one shared 8x9 multiplier: (c * (level+1)) >> 8.
// start -> R, G, B staged on the next three edges, done pulses with the full result.
module audiobar_ctrl_scale (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] color,
  input  logic [7:0]  level,
  output logic [23:0] result,
  output logic        done
);

  logic [1:0]  phase;
  logic        busy;
  logic [7:0]  r_stg;
  logic [7:0]  g_stg;
  logic [7:0]  b_stg;
  logic [1:0]  sel;
  logic [7:0]  chan;
  logic [8:0]  mult;
  logic [16:0] prod;
  logic [7:0]  scaled;

  always_comb begin
    sel = start ? 2'd0 : phase;
    case (sel)
      2'd0:    chan = color[23:16];
      2'd1:    chan = color[15:8];
      default: chan = color[7:0];
    endcase
    mult   = {1'b0, level} + 9'd1;
    prod   = {9'd0, chan} * {8'd0, mult};
    scaled = 8'(prod >> 8);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      phase <= 2'd0;
      done  <= 1'b0;
      r_stg <= 8'd0;
      g_stg <= 8'd0;
      b_stg <= 8'd0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy  <= 1'b0;
        phase <= 2'd0;
      end else if (start) begin
        r_stg <= scaled;
        phase <= 2'd1;
        busy  <= 1'b1;
      end else if (busy) begin
        if (phase == 2'd1) begin
          g_stg <= scaled;
          phase <= 2'd2;
        end else begin
          b_stg <= scaled;
          phase <= 2'd0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign result = {r_stg, g_stg, b_stg};

endmodule

// File: rtl/audiobar_ctrl.sv
// Audio bar overlay controller: host registers, PCM hold and peak meter, per-frame fade FSM.
// readdata 1 cycle after read; fade state at frame_start+1, faded colour at frame_start+5.
module audiobar_ctrl
  import audiobar_ctrl_pkg::*;
#(
  parameter logic [7:0]  FADE_STEP_DEF = 8'd8,
  parameter logic [23:0] COLOR_DEF     = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        pcm_valid,
  input  logic [15:0] pcm_l_in,
  input  logic [15:0] pcm_r_in,
  input  logic        vsyncn_in,
  output logic [15:0] pcm_l_out,
  output logic [15:0] pcm_r_out,
  output logic        mute_out,
  output logic [23:0] bar_color_out
);

  logic        vsync_q;
  logic        frame_start;
  logic        ctrl_enable;
  logic        ctrl_freeze;
  logic [7:0]  ctrl_step;
  logic [23:0] color_reg;
  logic [23:0] color_snap;
  fade_state_t state;
  fade_state_t state_nxt;
  logic [7:0]  level;
  logic [7:0]  level_nxt;
  logic [15:0] frame_cnt;
  logic [7:0]  peak_l;
  logic [7:0]  peak_r;
  logic [7:0]  mag_l;
  logic [7:0]  mag_r;
  logic [31:0] rd_mux;
  logic        scale_start;
  logic [23:0] scale_result;
  logic        scale_done;
  logic [8:0]  sum;
  logic [7:0]  lvl_up;
  logic [7:0]  lvl_dn;
  logic        go_up;
  logic        go_dn;
  logic        peak_rd;
  logic        wd_unused;

  assign frame_start = vsync_q & ~vsyncn_in;
  assign peak_rd     = read && (address == ADDR_PEAK);
  assign mag_l       = peak_mag(pcm_l_in);
  assign mag_r       = peak_mag(pcm_r_in);
  assign wd_unused   = ^{writedata[31:24], writedata[7:2]};

  // Fade FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_OFF;
      level <= 8'd0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  // Fade FSM: next state; transition and level step share the same frame_start
  always_comb begin
    sum    = {1'b0, level} + {1'b0, ctrl_step};
    lvl_up = (ctrl_step == 8'd0 || sum[8]) ? 8'hFF : sum[7:0];
    lvl_dn = (ctrl_step == 8'd0 || ctrl_step >= level) ? 8'd0 : level - ctrl_step;
    go_up  = 1'b0;
    go_dn  = 1'b0;
    if (frame_start) begin
      case (state)
        ST_OFF:                go_up = ctrl_enable;
        ST_FADEIN, ST_FADEOUT: begin
          go_up = ctrl_enable;
          go_dn = !ctrl_enable;
        end
        ST_ON:                 go_dn = !ctrl_enable;
        default:               ;
      endcase
    end
    state_nxt = state;
    level_nxt = level;
    if (go_up) begin
      level_nxt = lvl_up;
      state_nxt = (lvl_up == 8'hFF) ? ST_ON : ST_FADEIN;
    end else if (go_dn) begin
      level_nxt = lvl_dn;
      state_nxt = (lvl_dn == 8'd0) ? ST_OFF : ST_FADEOUT;
    end
  end

  // Fade FSM: outputs
  always_comb begin
    mute_out = (state == ST_OFF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b1;
      scale_start <= 1'b0;
      frame_cnt   <= 16'd0;
      color_snap  <= 24'd0;
    end else begin
      vsync_q     <= vsyncn_in;
      scale_start <= frame_start;
      if (frame_start) begin
        frame_cnt  <= frame_cnt + 16'd1;
        color_snap <= color_reg;
      end
    end
  end

  audiobar_ctrl_scale u_scale (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (scale_start),
    .abort   (frame_start),
    .color   (color_snap),
    .level   (level),
    .result  (scale_result),
    .done    (scale_done)
  );

  // A fresh frame_start supersedes a result that would land on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_color_out <= 24'd0;
    end else if (scale_done && !frame_start) begin
      bar_color_out <= scale_result;
    end
  end

  always_comb begin
    case (address)
      ADDR_CTRL:   rd_mux = {16'd0, ctrl_step, 6'd0, ctrl_freeze, ctrl_enable};
      ADDR_COLOR:  rd_mux = {8'd0, color_reg};
      ADDR_STATUS: rd_mux = {frame_cnt, level, 6'd0, state};
      default:     rd_mux = {16'd0, peak_r, peak_l};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata    <= 32'd0;
      ctrl_enable <= 1'b0;
      ctrl_freeze <= 1'b0;
      ctrl_step   <= FADE_STEP_DEF;
      color_reg   <= COLOR_DEF;
    end else begin
      if (read) begin
        readdata <= rd_mux;
      end
      if (write && address == ADDR_CTRL) begin
        ctrl_enable <= writedata[CTRL_ENABLE_BIT];
        ctrl_freeze <= writedata[CTRL_FREEZE_BIT];
        ctrl_step   <= writedata[CTRL_STEP_LSB +: 8];
      end
      if (write && address == ADDR_COLOR) begin
        color_reg <= writedata[23:0];
      end
    end
  end

  // A sample coincident with the clearing read seeds the meter instead of being dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcm_l_out <= 16'd0;
      pcm_r_out <= 16'd0;
      peak_l    <= 8'd0;
      peak_r    <= 8'd0;
    end else begin
      if (pcm_valid && !ctrl_freeze) begin
        pcm_l_out <= pcm_l_in;
        pcm_r_out <= pcm_r_in;
      end
      if (peak_rd) begin
        peak_l <= pcm_valid ? mag_l : 8'd0;
        peak_r <= pcm_valid ? mag_r : 8'd0;
      end else if (pcm_valid) begin
        if (mag_l > peak_l) peak_l <= mag_l;
        if (mag_r > peak_r) peak_r <= mag_r;
      end
    end
  end

endmodule

// File: tb/tb_audiobar_ctrl.sv
// Self-checking bench for audiobar_ctrl: spec-level model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_audiobar_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        pcm_valid = 1'b0;
  logic [15:0] pcm_l_in = 16'd0;
  logic [15:0] pcm_r_in = 16'd0;
  logic        vsyncn_in = 1'b1;
  logic [15:0] pcm_l_out;
  logic [15:0] pcm_r_out;
  logic        mute_out;
  logic [23:0] bar_color_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audiobar_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .pcm_valid     (pcm_valid),
    .pcm_l_in      (pcm_l_in),
    .pcm_r_in      (pcm_r_in),
    .vsyncn_in     (vsyncn_in),
    .pcm_l_out     (pcm_l_out),
    .pcm_r_out     (pcm_r_out),
    .mute_out      (mute_out),
    .bar_color_out (bar_color_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state, m_level, m_frames, m_en, m_frz, m_step, m_color;
  int m_pl, m_pr, m_peakl, m_peakr, m_rd, m_bar, m_vs, pend, pend_col;

  function automatic int mag(input logic [15:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v / 128;
  endfunction

  function automatic int scale(input int col, input int lvl);
    int r, g, b;
    r = ((col >> 16) & 255) * (lvl + 1) / 256;
    g = ((col >> 8) & 255) * (lvl + 1) / 256;
    b = (col & 255) * (lvl + 1) / 256;
    return r * 65536 + g * 256 + b;
  endfunction

  function automatic int reg_val(input int a);
    case (a)
      0:       return (m_step << 8) | (m_frz << 1) | m_en;
      1:       return m_color;
      2:       return (m_frames << 16) | (m_level << 8) | m_state;
      default: return (m_peakr << 8) | m_peakl;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_frames = 0; m_en = 0; m_frz = 0; m_step = 8;
    m_color = 24'hFFFFFF; m_pl = 0; m_pr = 0; m_peakl = 0; m_peakr = 0;
    m_rd = 0; m_bar = 0; m_vs = 1; pend = 0; pend_col = 0;
  endtask

  task automatic model_up();
    m_level = (m_step == 0) ? 255 : ((m_level + m_step > 255) ? 255 : m_level + m_step);
    m_state = (m_level == 255) ? 2 : 1;
  endtask

  task automatic model_down();
    m_level = (m_step == 0) ? 0 : ((m_level - m_step < 0) ? 0 : m_level - m_step);
    m_state = (m_level == 0) ? 0 : 3;
  endtask

  // Outputs compared mid-cycle, then the model consumes the inputs of the coming edge
  always @(negedge clk) begin
    bit fs;
    int ml, mr;
    if (!reset_n) model_reset();
    check("mute", {31'd0, mute_out}, (m_state == 0) ? 1 : 0);
    check("bar_color", {8'd0, bar_color_out}, m_bar);
    check("pcm_l", {16'd0, pcm_l_out}, m_pl);
    check("pcm_r", {16'd0, pcm_r_out}, m_pr);
    check("readdata", readdata, m_rd);
    if (reset_n) begin
      fs = (m_vs == 1) && !vsyncn_in;
      if (read) m_rd = reg_val(address);
      if (fs) begin
        case (m_state)
          0: if (m_en) model_up();
          1: if (m_en) model_up(); else model_down();
          2: if (!m_en) model_down();
          default: if (m_en) model_up(); else model_down();
        endcase
        m_frames = (m_frames + 1) % 65536;
        pend = 4;
        pend_col = scale(m_color, m_level);
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) m_bar = pend_col;
      end
      m_vs = vsyncn_in;
      if (pcm_valid && m_frz == 0) begin
        m_pl = pcm_l_in;
        m_pr = pcm_r_in;
      end
      ml = mag(pcm_l_in);
      mr = mag(pcm_r_in);
      if (read && address == 2'd3) begin
        m_peakl = pcm_valid ? ml : 0;
        m_peakr = pcm_valid ? mr : 0;
      end else if (pcm_valid) begin
        if (ml > m_peakl) m_peakl = ml;
        if (mr > m_peakr) m_peakr = mr;
      end
      if (write && address == 2'd0) begin
        m_en = writedata[0];
        m_frz = writedata[1];
        m_step = writedata[15:8];
      end
      if (write && address == 2'd1) m_color = writedata[23:0];
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick(1);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [31:0] v);
    address = a; writedata = v; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic pcm_send(input logic [15:0] l, input logic [15:0] r);
    pcm_valid = 1'b1; pcm_l_in = l; pcm_r_in = r;
    tick(1);
    pcm_valid = 1'b0;
  endtask

  task automatic vs_fall();
    vsyncn_in = 1'b0;
    tick(1);
    vsyncn_in = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int exp_lvl [5] = '{64, 128, 192, 255, 255};
    int exp_st  [5] = '{1, 1, 1, 2, 2};
    int exp_bar [5] = '{32'h204010, 32'h408020, 32'h60C030, 32'h80FF40, 32'h80FF40};

    tick(2);
    reset_n = 1'b1;
    check("rst_mute", {31'd0, mute_out}, 32'd1);
    check("rst_bar", {8'd0, bar_color_out}, 32'd0);
    host_read(2'd2, d); check("rst_status", d, 32'd0);
    host_read(2'd1, d); check("rst_color", d, 32'h00FFFFFF);
    host_read(2'd0, d); check("rst_ctrl", d, 32'h00000800);

    // fade in: step 64, five frames
    host_write(2'd1, 32'h0080FF40);
    host_write(2'd0, 32'h00004001);
    for (int i = 0; i < 5; i++) begin
      vs_fall();
      if (i == 0) check("mute_n1", {31'd0, mute_out}, 32'd0);
      host_read(2'd2, d);
      check("fade_level", {24'd0, d[15:8]}, exp_lvl[i]);
      check("fade_state", {30'd0, d[1:0]}, exp_st[i]);
      check("frame_cnt", {16'd0, d[31:16]}, i + 1);
      tick(2);
      if (i == 0) check("bar_n4", {8'd0, bar_color_out}, 32'd0);
      tick(1);
      check("bar_n5", {8'd0, bar_color_out}, exp_bar[i]);
    end

    // instantaneous fade out
    host_write(2'd0, 32'h00000000);
    vs_fall();
    check("off_mute", {31'd0, mute_out}, 32'd1);
    host_read(2'd2, d);
    check("off_status", {16'd0, d[15:0]}, 32'd0);
    tick(3);
    check("off_bar", {8'd0, bar_color_out}, 32'd0);

    // PCM peak meter
    pcm_send(16'h8000, 16'd0);
    pcm_send(16'd1000, 16'hFE0C);
    pcm_send(16'hFF38, 16'd2000);
    check("pcm_l_hold", {16'd0, pcm_l_out}, 32'h0000FF38);
    host_read(2'd3, d);
    check("peak_l", {24'd0, d[7:0]}, 32'h000000FF);
    check("peak_r", {24'd0, d[15:8]}, 32'h0000000F);
    address = 2'd3; read = 1'b1; pcm_valid = 1'b1; pcm_l_in = 16'd16384; pcm_r_in = 16'd0;
    tick(1);
    read = 1'b0; pcm_valid = 1'b0;
    check("peak_cleared", readdata, 32'd0);
    host_read(2'd3, d);
    check("peak_coincident", {24'd0, d[7:0]}, 32'h00000080);

    // freeze
    host_write(2'd0, 32'h00000002);
    pcm_send(16'h1234, 16'h5678);
    check("freeze_hold", {16'd0, pcm_l_out}, 32'h00004000);
    host_write(2'd0, 32'h00000000);
    check("unfreeze_wait", {16'd0, pcm_l_out}, 32'h00004000);
    pcm_send(16'h1234, 16'h5678);
    check("unfreeze_load", {16'd0, pcm_l_out}, 32'h00001234);

    // read and write in the same cycle
    address = 2'd1; read = 1'b1; write = 1'b1; writedata = 32'h00123456;
    tick(1);
    read = 1'b0; write = 1'b0;
    check("rw_pre_value", readdata, 32'h0080FF40);
    host_read(2'd1, d);
    check("rw_post_value", d, 32'h00123456);

    // second frame_start at N+3 restarts the colour sequence
    host_write(2'd1, 32'h0080FF40);
    host_write(2'd0, 32'h00004001);
    vsyncn_in = 1'b0;
    tick(1);
    vsyncn_in = 1'b1;
    tick(2);
    vsyncn_in = 1'b0;
    tick(1);
    vsyncn_in = 1'b1;
    tick(1);
    check("abort_n2", {8'd0, bar_color_out}, 32'd0);
    tick(2);
    check("abort_n4", {8'd0, bar_color_out}, 32'd0);
    tick(1);
    check("abort_n5", {8'd0, bar_color_out}, 32'h00408020);

    // reset in the middle of a colour sequence
    vs_fall();
    tick(1);
    reset_n = 1'b0;
    #1;
    check("mrst_mute", {31'd0, mute_out}, 32'd1);
    check("mrst_bar", {8'd0, bar_color_out}, 32'd0);
    check("mrst_pcm_l", {16'd0, pcm_l_out}, 32'd0);
    check("mrst_pcm_r", {16'd0, pcm_r_out}, 32'd0);
    check("mrst_readdata", readdata, 32'd0);
    tick(2);
    reset_n = 1'b1;
    host_read(2'd2, d); check("mrst_status", d, 32'd0);
    host_read(2'd1, d); check("mrst_color", d, 32'h00FFFFFF);
    host_read(2'd3, d); check("mrst_peak", d, 32'd0);
    tick(6);
    check("mrst_bar_late", {8'd0, bar_color_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
